// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//
// Run controller for the core pipeline. After power-on reset it drives a
// multi-cycle reset_ACT pulse and then lets the core run. From the debug/system
// side it accepts halt/resume requests and a soft-reset pulse that restarts the
// reset sequence from any state.
//
// States: RESET -> RUN -> DRAIN -> HALTED -> RUN ...
//   RESET  : reset_ACT=1, counts RESET_CYCLES cycles
//   RUN    : main_ACT=1
//   DRAIN  : main_ACT=1, stall=1, waits for pipe_idle
//   HALTED : stall=1, halted=1
//
// Optional feature (macro RUN_CTRL_DRAIN_TIMEOUT_EN):
//   DRAIN is bounded to DRAIN_LIMIT cycles. On expiry with the pipeline still
//   busy the core is forced to HALTED and the sticky drain_tmo flag is set.
//   Without the macro DRAIN waits for pipe_idle forever and drain_tmo is 0.
//
// Parameters:
//   RESET_CYCLES  reset_ACT length in cycles (1..255, < 2**CNT_W)
//   CNT_W         width of the shared cycle counter
//   DRAIN_LIMIT   drain timeout in cycles (timeout build only)
//
// Ports:
//   CLK           in  core clock, rising edge
//   RST           in  asynchronous active-low reset
//   halt_req      in  level, halt request (acted on in RUN)
//   resume_req    in  level, resume request (acted on in HALTED)
//   soft_rst_req  in  pulse, restart reset sequence (highest priority)
//   pipe_idle     in  pipeline has no instruction in flight
//   reset_ACT     out core reset activation
//   main_ACT      out core run activation
//   stall         out freeze fetch (DRAIN, HALTED)
//   halted        out core halted (HALTED)
//   resume_ack    out one-cycle pulse in the first RUN cycle after HALTED
//   drain_tmo     out sticky drain-timeout flag
//
// All outputs are decoded from state registers only; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 8,
  parameter int DRAIN_LIMIT  = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic halt_req,
  input  logic resume_req,
  input  logic soft_rst_req,
  input  logic pipe_idle,
  output logic reset_ACT,
  output logic main_ACT,
  output logic stall,
  output logic halted,
  output logic resume_ack,
  output logic drain_tmo
);

  // Elaboration-time parameter sanity checks.
  if (RESET_CYCLES < 1 || RESET_CYCLES > 255 || RESET_CYCLES >= (1 << CNT_W)) begin : g_bad_reset_cycles
    $error("core_run_ctrl: RESET_CYCLES out of range for CNT_W");
  end
  if (DRAIN_LIMIT < 1 || DRAIN_LIMIT > (1 << CNT_W)) begin : g_bad_drain_limit
    $error("core_run_ctrl: DRAIN_LIMIT out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_RST_LAST = CNT_W'(RESET_CYCLES - 1);
`ifdef RUN_CTRL_DRAIN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_DRAIN_LAST = CNT_W'(DRAIN_LIMIT - 1);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_resume_ack;
  logic             w_resume_ack_nxt;
  logic             r_drain_tmo;
  logic             w_drain_tmo_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_resume_ack <= 1'b0;
      r_drain_tmo  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resume_ack <= w_resume_ack_nxt;
      r_drain_tmo  <= w_drain_tmo_nxt;
    end
  end

  // The counter is zero outside of the state that uses it, so every entry
  // into RESET or DRAIN starts counting from zero without extra clearing.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = '0;
    w_resume_ack_nxt = 1'b0;
    w_drain_tmo_nxt  = r_drain_tmo;

    if (soft_rst_req) begin
      w_state_nxt     = ST_RESET;
      w_drain_tmo_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (r_cnt == LP_RST_LAST) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_idle) begin
            w_state_nxt = ST_HALTED;
          end
`ifdef RUN_CTRL_DRAIN_TIMEOUT_EN
          else if (r_cnt == LP_DRAIN_LAST) begin
            w_state_nxt     = ST_HALTED;
            w_drain_tmo_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`endif
        end
        ST_HALTED: begin
          // A still-asserted halt_req wins over resume_req.
          if (resume_req && !halt_req) begin
            w_state_nxt      = ST_RUN;
            w_resume_ack_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_RESET;
        end
      endcase
    end
  end

  assign reset_ACT  = (r_state == ST_RESET);
  assign main_ACT   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign stall      = (r_state == ST_DRAIN) || (r_state == ST_HALTED);
  assign halted     = (r_state == ST_HALTED);
  assign resume_ack = r_resume_ack;
`ifdef RUN_CTRL_DRAIN_TIMEOUT_EN
  assign drain_tmo  = r_drain_tmo;
`else
  assign drain_tmo  = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_run_ctrl
//
// Scoreboard bench for core_run_ctrl. A driver applies one input vector per
// cycle shortly after the rising edge, pushes the outputs the reference model
// predicts for that cycle into a queue, then advances the model across the
// coming edge. A monitor samples the DUT on each falling edge and compares it
// with the oldest queued expectation.
//
// The reference model tracks the core mode plus a count of reset cycles still
// owed and the number of cycles spent draining.
// -----------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam int RC  = 4;
  localparam int DL  = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic halt_req = 1'b0;
  logic resume_req = 1'b0;
  logic soft_rst_req = 1'b0;
  logic pipe_idle = 1'b0;
  logic reset_ACT, main_ACT, stall, halted, resume_ack, drain_tmo;

  core_run_ctrl #(
    .RESET_CYCLES(RC),
    .CNT_W(8),
    .DRAIN_LIMIT(DL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .halt_req(halt_req),
    .resume_req(resume_req),
    .soft_rst_req(soft_rst_req),
    .pipe_idle(pipe_idle),
    .reset_ACT(reset_ACT),
    .main_ACT(main_ACT),
    .stall(stall),
    .halted(halted),
    .resume_ack(resume_ack),
    .drain_tmo(drain_tmo)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ra, ma, st, ha, ack, tmo;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  localparam int M_RESET = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  int   m_mode;
  int   m_rst_left;    // reset_ACT cycles still to be shown, including this one
  int   m_drained;     // cycles already spent in DRAIN
  logic m_ack;
  logic m_tmo;

  task automatic model_reset();
    m_mode     = M_RESET;
    m_rst_left = RC;
    m_drained  = 0;
    m_ack      = 1'b0;
    m_tmo      = 1'b0;
  endtask

  task automatic model_edge(input logic h, input logic r, input logic s, input logic p);
    m_ack = 1'b0;
    if (s) begin
      model_reset();
    end else if (m_mode == M_RESET) begin
      m_rst_left = m_rst_left - 1;
      if (m_rst_left == 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (h) begin
        m_mode    = M_DRAIN;
        m_drained = 0;
      end
    end else if (m_mode == M_DRAIN) begin
      m_drained = m_drained + 1;
      if (p) begin
        m_mode = M_HALT;
      end
`ifdef RUN_CTRL_DRAIN_TIMEOUT_EN
      else if (m_drained == DL) begin
        m_mode = M_HALT;
        m_tmo  = 1'b1;
      end
`endif
    end else begin
      if (r && !h) begin
        m_mode = M_RUN;
        m_ack  = 1'b1;
      end
    end
  endtask

  function automatic exp_t model_out(input int c);
    exp_t e;
    e.ra  = (m_mode == M_RESET);
    e.ma  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
    e.st  = (m_mode == M_DRAIN) || (m_mode == M_HALT);
    e.ha  = (m_mode == M_HALT);
    e.ack = m_ack;
    e.tmo = m_tmo;
    e.cyc = c;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic h, input logic r,
                      input logic s, input logic p);
    @(posedge CLK);
    #1;
    RST          = rst;
    halt_req     = h;
    resume_req   = r;
    soft_rst_req = s;
    pipe_idle    = p;
    cyc          = cyc + 1;
    if (!rst) model_reset();
    q.push_back(model_out(cyc));
    if (rst) model_edge(h, r, s, p);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic act, input logic exp_v, input int c);
    total = total + 1;
    if (act !== exp_v) begin
      bad = bad + 1;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, c, act, exp_v);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("reset_ACT",  reset_ACT,  e.ra,  e.cyc);
      chk("main_ACT",   main_ACT,   e.ma,  e.cyc);
      chk("stall",      stall,      e.st,  e.cyc);
      chk("halted",     halted,     e.ha,  e.cyc);
      chk("resume_ack", resume_ack, e.ack, e.cyc);
      chk("drain_tmo",  drain_tmo,  e.tmo, e.cyc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic rst_v, h_v, r_v, s_v, p_v;
    int   idle_pct;
    model_reset();

    // Held in reset, then release: 4 cycles of reset_ACT, then RUN.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt with a busy pipeline for three DRAIN cycles, then idle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Resume while halt is still requested: stays halted. Then a clean resume.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt with pipeline already idle: one DRAIN cycle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Soft reset while draining; halt_req dropped during drain does not abort.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt requested during RESET is acted on in the first RUN cycle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Soft reset restart during RESET, then async reset at count 2.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Long busy drain (exercises the timeout when compiled in), then soft reset.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; idle probability changes in phases so that both
    // short and long drains occur.
    idle_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) idle_pct = ($urandom_range(0, 1) == 0) ? 5 : 60;
      rst_v = ($urandom_range(0, 299) != 0);
      h_v   = ($urandom_range(0, 99) < 30);
      r_v   = ($urandom_range(0, 99) < 40);
      s_v   = ($urandom_range(0, 59) == 0);
      p_v   = ($urandom_range(0, 99) < idle_pct);
      step(rst_v, h_v, r_v, s_v, p_v);
    end

    repeat (3) @(negedge CLK);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
